// File: rtl/mips_pkg.sv
// Shared types and sizing for the MIPS register file.
// Defaults match the classic 32 x 32-bit MIPS integer register set.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder_5x32.sv
// One-hot write-enable decoder for the register file.
// Entry 0 is the hard-wired zero register and is never enabled.
module decoder_5x32 #(
    parameter int ADDR_W = 5
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/mips_register_file.sv
// Two-read, one-write MIPS register file with saturating write counter.
// Optional write-before-read bypass: define REGFILE_BYPASS_EN.
module mips_register_file #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    output logic [15:0]           wr_count
);

    import mips_pkg::*;

    localparam int NUM = 2**REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    logic [NUM-1:0]    we;
    logic              commit;
    logic [DATA_W-1:0] regs [NUM];

    decoder_5x32 #(
        .ADDR_W (REG_ADDR_W)
    ) u_dec (
        .en     (reg_write),
        .addr   (wr_addr),
        .onehot (we)
    );

    assign commit = |we;

    // Entry 0 is never enabled, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (we[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (commit && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    logic [DATA_W-1:0] rs_store;
    logic [DATA_W-1:0] rt_store;

    assign rs_store = (rs_addr == ZERO) ? '0 : regs[rs_addr];
    assign rt_store = (rt_addr == ZERO) ? '0 : regs[rt_addr];

`ifdef REGFILE_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    // Forward the in-flight write; the zero register is excluded via commit.
    assign rs_hit = rst_n && commit && (rs_addr == wr_addr);
    assign rt_hit = rst_n && commit && (rt_addr == wr_addr);

    assign rs_data = rs_hit ? wr_data : rs_store;
    assign rt_data = rt_hit ? wr_data : rt_store;
`else
    assign rs_data = rs_store;
    assign rt_data = rt_store;
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: directed writes and reads,
// expectations queued by stimulus and checked by a negedge monitor.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] wr_count;

    mips_register_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_write (reg_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expectation per flagged cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s: scoreboard empty", "sb_underflow");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rs_data !== e.rs || rt_data !== e.rt || wr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got rs=%h rt=%h cnt=%h want rs=%h rt=%h cnt=%h",
                             e.name, rs_data, rt_data, wr_count, e.rs, e.rt, e.cnt);
                end
            end
        end
    end

    task automatic expect_rd(input string nm, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [31:0] ers, input logic [31:0] ert,
                             input logic [15:0] ecnt);
        exp_t e;
        rs_addr = ra;
        rt_addr = rb;
        e.name = nm;
        e.rs = ers;
        e.rt = ert;
        e.cnt = ecnt;
        sb.push_back(e);
        chk_en = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 reg_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL %s: simulation time limit reached", "timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_r9;
        repeat (2) @(posedge clk);
        #1;
        expect_rd("reset_state", 5'd8, 5'd31, 32'h0, 32'h0, 16'h0);
        rst_n = 1'b1;

        do_write(5'd8, 32'hDEADBEEF);
        expect_rd("wr_r8", 5'd8, 5'd0, 32'hDEADBEEF, 32'h0, 16'd1);

        // Write to r0 while reading r0 in the same cycle: never bypassed.
        reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        expect_rd("r0_same_cycle", 5'd0, 5'd0, 32'h0, 32'h0, 16'd1);
        reg_write = 1'b0;
        expect_rd("r0_after", 5'd0, 5'd8, 32'h0, 32'hDEADBEEF, 16'd1);

        do_write(5'd9, 32'h11111111);
`ifdef REGFILE_BYPASS_EN
        exp_r9 = 32'h12345678;
`else
        exp_r9 = 32'h11111111;
`endif
        reg_write = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678;
        expect_rd("r9_same_cycle", 5'd8, 5'd9, 32'hDEADBEEF, exp_r9, 16'd2);
        reg_write = 1'b0;
        expect_rd("r9_next", 5'd9, 5'd9, 32'h12345678, 32'h12345678, 16'd3);

        do_write(5'd31, 32'hA5A5A5A5);
        do_write(5'd1, 32'h00000001);
        expect_rd("r31_r1", 5'd31, 5'd1, 32'hA5A5A5A5, 32'h00000001, 16'd5);
        expect_rd("same_addr", 5'd8, 5'd8, 32'hDEADBEEF, 32'hDEADBEEF, 16'd5);

        // reg_write low: address/data churn must have no effect.
        for (int i = 0; i < 10; i++) begin
            wr_addr = 5'(i * 7 + 1);
            wr_data = 32'hCAFE0000 + 32'(i);
            @(posedge clk);
            #1;
        end
        expect_rd("hold_r8_r9", 5'd8, 5'd9, 32'hDEADBEEF, 32'h12345678, 16'd5);
        expect_rd("hold_r31_r1", 5'd31, 5'd1, 32'hA5A5A5A5, 32'h00000001, 16'd5);

        // Mid-run reset with a write pending: reset wins, clears asynchronously.
        rst_n = 1'b0;
        reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'h55555555;
        expect_rd("async_rst", 5'd8, 5'd9, 32'h0, 32'h0, 16'd0);
        for (int i = 0; i < 32; i++) begin
            expect_rd($sformatf("rst_sweep%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0, 16'd0);
        end
        reg_write = 1'b0;
        rst_n = 1'b1;
        expect_rd("post_rst_r5", 5'd5, 5'd8, 32'h0, 32'h0, 16'd0);

        do_write(5'd5, 32'h00000077);
        expect_rd("first_wr", 5'd5, 5'd0, 32'h00000077, 32'h0, 16'd1);

        // Drive the counter to 16'hFFFE with back-to-back writes.
        reg_write = 1'b1; wr_addr = 5'd2; wr_data = 32'h0BADF00D;
        repeat (65533) @(posedge clk);
        #1 reg_write = 1'b0;
        expect_rd("cnt_fffe", 5'd2, 5'd5, 32'h0BADF00D, 32'h00000077, 16'hFFFE);
        do_write(5'd3, 32'h00000003);
        expect_rd("cnt_ffff", 5'd3, 5'd2, 32'h00000003, 32'h0BADF00D, 16'hFFFF);
        do_write(5'd3, 32'h80000000);
        do_write(5'd4, 32'h7FFFFFFF);
        expect_rd("cnt_sat", 5'd3, 5'd4, 32'h80000000, 32'h7FFFFFFF, 16'hFFFF);

        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d left, want 0", "sb_drain", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
